// File: rtl/matrix_fifo_filler.sv
// Fill engine for the MAC matrix-vector unit: fetches NUM_ROWS A rows plus one B vector over
// an Avalon-MM read master and serialises each word, element 0 first, into its input FIFO.
module matrix_fifo_filler #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ROW_LEN    = 8,
  parameter int unsigned           NUM_ROWS   = 8,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [ADDR_WIDTH-1:0]         mem_address,
  output logic                          mem_read,
  input  logic                          mem_waitrequest,
  input  logic [ROW_LEN*DATA_WIDTH-1:0] mem_readdata,
  input  logic                          mem_readdatavalid,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [NUM_ROWS:0]             fifo_wrreq,
  input  logic [NUM_ROWS:0]             fifo_full
);

  localparam int unsigned RowW  = $clog2(NUM_ROWS + 1);
  localparam int unsigned ByteW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int unsigned WordW = ROW_LEN * DATA_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StWrite,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [RowW-1:0]    row_q, row_d;
  logic [ByteW-1:0]   byte_idx_q, byte_idx_d;
  logic [WordW-1:0]   latch_q, latch_d;
  logic               wr_en;
  logic               last_byte;
  logic               last_row;

  assign last_byte = (byte_idx_q == ByteW'(ROW_LEN - 1));
  assign last_row  = (row_q == RowW'(NUM_ROWS));
  // A full target FIFO simply stalls the current element; nothing advances.
  assign wr_en     = (state_q == StWrite) && !fifo_full[row_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      row_q      <= '0;
      byte_idx_q <= '0;
      latch_q    <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      byte_idx_q <= byte_idx_d;
      latch_q    <= latch_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    byte_idx_d = byte_idx_q;
    latch_d    = latch_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StReq;
          row_d   = '0;
        end
      end
      StReq: begin
        if (!mem_waitrequest) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem_readdatavalid) begin
          latch_d    = mem_readdata;
          byte_idx_d = '0;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        if (wr_en) begin
          if (!last_byte) begin
            byte_idx_d = byte_idx_q + 1'b1;
          end else if (last_row) begin
            state_d = StDone;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = StReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy        = (state_q != StIdle) && (state_q != StDone);
  assign done        = (state_q == StDone);
  assign mem_read    = (state_q == StReq);
  assign mem_address = BASE_ADDR + ADDR_WIDTH'(row_q);

  always_comb begin
    fifo_wrreq = '0;
    fifo_data  = '0;
    if (state_q == StWrite) begin
      fifo_data = latch_q[byte_idx_q*DATA_WIDTH +: DATA_WIDTH];
      if (!fifo_full[row_q]) begin
        fifo_wrreq[row_q] = 1'b1;
      end
    end
  end

  wrreq_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(fifo_wrreq));
  wrreq_not_full_a: assert property (@(posedge clk) disable iff (!rst_n)
                                     (fifo_wrreq & fifo_full) == '0);

endmodule

// File: tb/tb_matrix_fifo_filler.sv
// Bench for matrix_fifo_filler: Avalon slave and FIFO sink models, a scenario table with
// expected completion times, hand-written reset/restart sequences and randomized fills.
module tb_matrix_fifo_filler;

  localparam int unsigned DW   = 8;
  localparam int unsigned RL   = 8;
  localparam int unsigned NR   = 8;
  localparam int unsigned AW   = 32;
  localparam int unsigned NF   = NR + 1;
  localparam logic [AW-1:0] BASE = '0;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             busy;
  logic             done;
  logic [AW-1:0]    mem_address;
  logic             mem_read;
  logic             mem_waitrequest;
  logic [RL*DW-1:0] mem_readdata;
  logic             mem_readdatavalid;
  logic [DW-1:0]    fifo_data;
  logic [NR:0]      fifo_wrreq;
  logic [NR:0]      fifo_full;

  always #5 clk = ~clk;

  matrix_fifo_filler #(
    .DATA_WIDTH (DW),
    .ROW_LEN    (RL),
    .NUM_ROWS   (NR),
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .fifo_data         (fifo_data),
    .fifo_wrreq        (fifo_wrreq),
    .fifo_full         (fifo_full)
  );

  typedef struct {
    int wait_row;
    int wait_cnt;
    int full_fifo;
    int full_at;
    int full_len;
    int exp_done;
  } scen_t;

  // Scenario configuration, written by the main sequence only.
  int               wait_row;
  int               wait_cnt;
  int               full_fifo;
  int               full_at;
  int               full_len;
  bit               rand_mode;
  logic [RL*DW-1:0] mem [NF];

  // Observations, written by the environment process only.
  logic [DW-1:0]    got [NF][$];
  logic [AW-1:0]    acc_q [$];
  int               viol;
  int               req_cycles;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Memory slave (read latency 1, programmable waitstates) and FIFO sink.
  bit            acc_pend;
  bit            in_req;
  bit            hold_prev;
  bit            full_fired;
  int            wait_left;
  int            full_left;
  int            acc_idx;
  logic [AW-1:0] hold_addr;

  initial begin
    mem_waitrequest   = 1'b0;
    mem_readdatavalid = 1'b0;
    mem_readdata      = '0;
    fifo_full         = '0;
    viol              = 0;
    req_cycles        = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc_pend   = 1'b0;
        in_req     = 1'b0;
        hold_prev  = 1'b0;
        full_fired = 1'b0;
        wait_left  = 0;
        full_left  = 0;
        viol       = 0;
        req_cycles = 0;
        for (int r = 0; r < NF; r++) got[r].delete();
        acc_q.delete();
        mem_waitrequest   = 1'b0;
        mem_readdatavalid = 1'b0;
        fifo_full         = '0;
      end else begin
        if (acc_pend && mem_read) viol++;
        if (mem_read) req_cycles++;
        if ($countones(fifo_wrreq) > 1) viol++;
        if ((fifo_wrreq & fifo_full) != '0) viol++;
        for (int r = 0; r < NF; r++) begin
          if (fifo_wrreq[r]) got[r].push_back(fifo_data);
        end
        if (hold_prev && (!mem_read || mem_address != hold_addr)) viol++;
        hold_prev = mem_read && mem_waitrequest;
        hold_addr = mem_address;
        acc_pend  = mem_read && !mem_waitrequest;
        if (acc_pend) begin
          acc_q.push_back(mem_address);
          acc_idx = int'(mem_address - BASE);
        end
        @(posedge clk);
        #1;
        if (rst_n) begin
          if (acc_pend) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = (acc_idx >= 0 && acc_idx < NF) ? mem[acc_idx] : '0;
            in_req            = 1'b0;
          end else begin
            mem_readdata      = {$urandom, $urandom};
            mem_readdatavalid = rand_mode && ($urandom_range(0, 7) == 0);
          end
          if (mem_read) begin
            if (!in_req) begin
              in_req    = 1'b1;
              wait_left = rand_mode ? int'($urandom_range(0, 3)) :
                          ((int'(mem_address - BASE) == wait_row) ? wait_cnt : 0);
            end
            mem_waitrequest = (wait_left != 0);
            if (wait_left != 0) wait_left--;
          end else begin
            mem_waitrequest = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
          end
          if (rand_mode) begin
            fifo_full = NF'($urandom) & NF'($urandom);
          end else begin
            if (!full_fired && full_fifo >= 0 && full_fifo < NF &&
                got[full_fifo].size() == full_at) begin
              full_fired = 1'b1;
              full_left  = full_len;
            end
            fifo_full = '0;
            if (full_left > 0) begin
              fifo_full[full_fifo] = 1'b1;
              full_left--;
            end
          end
        end
      end
    end
  end

  task automatic load_nominal();
    for (int r = 0; r < NR; r++) mem[r] = {RL{8'(r + 1)}};
    mem[NR] = 64'h0807060504030201;
  endtask

  task automatic load_random();
    for (int r = 0; r < NF; r++) mem[r] = {$urandom, $urandom};
  endtask

  task automatic set_cfg(input scen_t s);
    wait_row  = s.wait_row;
    wait_cnt  = s.wait_cnt;
    full_fifo = s.full_fifo;
    full_at   = s.full_at;
    full_len  = s.full_len;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Pulses start, then counts clocks after the sampling edge until done rises.
  task automatic fill_and_wait(input int budget, output int n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_to_read", mem_read, 1);
    chk("first_address", mem_address, BASE);
    chk("busy_after_start", busy, 1);
    n = 0;
    while (!done && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Expected FIFO contents: each word split into elements, element 0 first.
  task automatic check_contents(input int copies, input int exp_acc);
    for (int r = 0; r < NF; r++) begin
      int bad;
      logic [RL*DW-1:0] w;
      logic [DW-1:0] e;
      bad = 0;
      w = mem[r];
      chk($sformatf("fifo%0d_count", r), got[r].size(), copies * RL);
      for (int i = 0; i < got[r].size() && i < copies * RL; i++) begin
        e = w[(i % RL) * DW +: DW];
        if (got[r][i] != e) bad++;
      end
      chk($sformatf("fifo%0d_bytes", r), bad, 0);
    end
    chk("read_accepts", acc_q.size(), exp_acc);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < acc_q.size(); i++) begin
        if (acc_q[i] != BASE + AW'(i % NF)) bad++;
      end
      chk("read_addresses", bad, 0);
    end
    chk("protocol_violations", viol, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    scen_t tbl [5];
    int n;
    int bad;

    rst_n     = 1'b0;
    start     = 1'b0;
    rand_mode = 1'b0;
    tbl[0] = '{-1, 0, -1, 0, 0, 90};
    tbl[1] = '{ 2, 3, -1, 0, 0, 93};
    tbl[2] = '{-1, 0,  5, 3, 4, 94};
    tbl[3] = '{ 8, 1,  8, 7, 2, 93};
    tbl[4] = '{ 0, 5,  1, 1, 1, 96};
    set_cfg(tbl[0]);
    load_nominal();

    // Reset values, then idle with start low.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_fifo_wrreq", fifo_wrreq, 0);
    chk("rst_fifo_data", fifo_data, 0);
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_no_reads", req_cycles, 0);

    // Scenario table: waitstates and full stalls with exact completion times.
    for (int s = 0; s < 5; s++) begin
      do_reset();
      load_nominal();
      set_cfg(tbl[s]);
      fill_and_wait(400, n);
      chk($sformatf("s%0d_done_clk", s), n, tbl[s].exp_done);
      check_contents(1, NF);
    end
    set_cfg(tbl[0]);

    // Reset in the middle of row 4, then a clean refill from row 0.
    do_reset();
    load_nominal();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (got[4].size() < 3 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("midrst_row4_reached", got[4].size(), 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_wrreq", fifo_wrreq, 0);
    chk("midrst_mem_read", mem_read, 0);
    chk("midrst_done", done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fill_and_wait(400, n);
    chk("refill_done_clk", n, 90);
    check_contents(1, NF);

    // start held through DONE restarts one clock later; start while busy is ignored.
    do_reset();
    load_nominal();
    start = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    while (!done && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold_first_done_clk", n, 90);
    @(posedge clk);
    #1;
    chk("restart_done_low", done, 0);
    chk("restart_busy", busy, 1);
    chk("restart_mem_read", mem_read, 1);
    chk("restart_address", mem_address, BASE);
    n = 0;
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      n++;
      if (!busy) bad++;
    end
    chk("start_while_busy_stays_busy", bad, 0);
    start = 1'b0;
    while (!done && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold_second_done_clk", n, 90);
    check_contents(2, 2 * NF);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("done_stays", done, 1);
    chk("done_no_new_read", acc_q.size(), 2 * NF);

    // Randomized fills: random data, waitstates, full patterns and stray valids.
    for (int k = 0; k < 3; k++) begin
      do_reset();
      load_random();
      rand_mode = 1'b1;
      fill_and_wait(3000, n);
      chk($sformatf("rand%0d_done", k), done, 1);
      rand_mode = 1'b0;
      check_contents(1, NF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
